// File: rtl/serial_deser_pkg.sv
// Shared types and sizing helpers for the serial word deserializer.
package serial_deser_pkg;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// One-word valid/ready holding register with sticky overflow on a dropped word.
module deser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_word,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overflow
);

  logic [WIDTH-1:0] word_q;
  logic             valid_q, ovf_q;
  logic             room, drop;

  assign room = !valid_q || word_ready;
  assign drop = load_word && !room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load_word && room) begin
        word_q  <= word_in;
        valid_q <= 1'b1;
      end else if (valid_q && word_ready) begin
        valid_q <= 1'b0;
      end
      // a drop in the same cycle as a clear must still be reported
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/serial_word_deser.sv
// Packs a strobed serial bit stream into WIDTH-bit words framed by sof.
module serial_word_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_en,
  input  logic                     sof,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     sync_err,
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             serr_q;

  logic [WIDTH-1:0] first_bit, shifted;
  logic             start, resync, complete;

  always_comb begin
    first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bit_in} : {bit_in, {(WIDTH-1){1'b0}}};
    shifted   = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
    start     = bit_en && sof;
    // sof always wins, so a resync can never also complete a word
    resync    = start && (state_q == COLLECT) && (cnt_q != '0);
    complete  = bit_en && !sof && (state_q == COLLECT) && (cnt_q == CW'(WIDTH-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      serr_q  <= 1'b0;
    end else begin
      serr_q <= resync;
      if (start) begin
        state_q <= COLLECT;
        sr_q    <= first_bit;
        cnt_q   <= CW'(1);
      end else if (bit_en && state_q == COLLECT) begin
        if (complete) begin
          sr_q  <= '0;
          cnt_q <= '0;
        end else begin
          sr_q  <= shifted;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  deser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_word  (complete),
    .word_in    (shifted),
    .word_ready (word_ready),
    .clr_ovf    (clr_ovf),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overflow   (overflow)
  );

  assign sync_err = serr_q;
  assign bit_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed plus random stimulus on MSB-first and LSB-first instances against a bit-queue model.
module tb_serial_word_deser;

  logic clk = 1'b0;
  logic rst, bit_in, bit_en, sof, word_ready, clr_ovf;
  logic [7:0] wo_m, wo_l;
  logic       wv_m, wv_l, ov_m, ov_l, se_m, se_l;
  logic [3:0] bc_m, bc_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_word_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .sof(sof),
    .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
    .overflow(ov_m), .clr_ovf(clr_ovf), .sync_err(se_m), .bit_cnt(bc_m));

  serial_word_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .sof(sof),
    .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
    .overflow(ov_l), .clr_ovf(clr_ovf), .sync_err(se_l), .bit_cnt(bc_l));

  // reference: bits received so far in the current word, plus the held word
  logic       mq[$];
  logic       m_frame, m_valid, m_ovf, m_serr;
  logic [7:0] m_wm, m_wl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_frame = 0; m_valid = 0; m_ovf = 0; m_serr = 0; m_wm = 0; m_wl = 0;
  endtask

  task automatic model_step();
    logic       done = 0;
    logic [7:0] nm = 0, nl = 0;
    m_serr = 0;
    if (bit_en) begin
      if (sof) begin
        if (m_frame && mq.size() != 0) m_serr = 1;
        mq.delete();
        mq.push_back(bit_in);
        m_frame = 1;
      end else if (m_frame) begin
        mq.push_back(bit_in);
        if (mq.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            nm[7-i] = mq[i];
            nl[i]   = mq[i];
          end
          mq.delete();
          done = 1;
        end
      end
    end
    if (done && m_valid && !word_ready) m_ovf = 1;
    else if (clr_ovf)                   m_ovf = 0;
    if (done && (!m_valid || word_ready)) begin
      m_valid = 1; m_wm = nm; m_wl = nl;
    end else if (m_valid && word_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("valid_m", wv_m, m_valid);      chk("valid_l", wv_l, m_valid);
    chk("word_m", wo_m, m_wm);          chk("word_l", wo_l, m_wl);
    chk("ovf_m", ov_m, m_ovf);          chk("ovf_l", ov_l, m_ovf);
    chk("serr_m", se_m, m_serr);        chk("serr_l", se_l, m_serr);
    chk("cnt_m", bc_m, mq.size());      chk("cnt_l", bc_l, mq.size());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drv(input logic en, input logic b, input logic s);
    bit_en = en; bit_in = b; sof = s;
    tick();
  endtask

  task automatic send_word(input logic [7:0] w, input logic s);
    for (int i = 0; i < 8; i++) drv(1'b1, w[7-i], s && (i == 0));
  endtask

  initial begin
    logic [7:0] b1 = 8'b1010_0101;
    logic [7:0] b2 = 8'b1100_0000;
    rst = 1; bit_in = 0; bit_en = 0; sof = 0; word_ready = 1; clr_ovf = 0;
    model_reset();
    @(posedge clk); #1;
    check_all();
    chk("reset_word", wo_m, 0);
    @(negedge clk); rst = 0;

    // 1: A5 arrives one cycle after the last strobe, valid for one cycle
    send_word(b1, 1);
    chk("t1_valid", wv_m, 1); chk("t1_word_m", wo_m, 8'hA5); chk("t1_word_l", wo_l, 8'hA5);
    drv(0, 0, 0);
    chk("t1_valid_drop", wv_m, 0);

    // 2: bit order
    send_word(b2, 1);
    chk("t2_word_m", wo_m, 8'hC0); chk("t2_word_l", wo_l, 8'h03);
    drv(0, 0, 0);

    // 3: overflow with a stalled consumer
    word_ready = 0;
    send_word(8'h11, 1);
    send_word(8'h22, 0);
    chk("t3_ovf", ov_m, 1); chk("t3_keep", wo_m, 8'h11); chk("t3_valid", wv_m, 1);
    clr_ovf = 1; drv(0, 0, 0); clr_ovf = 0;
    chk("t3_clr", ov_m, 0);
    word_ready = 1; drv(0, 0, 0);
    chk("t3_xfer", wv_m, 0); chk("t3_last", wo_m, 8'h11);

    // 4: resync after three bits
    drv(1, 1, 1); drv(1, 1, 0); drv(1, 1, 0);
    send_word(8'h5A, 1);
    chk("t4_word", wo_m, 8'h5A); chk("t4_cnt", bc_m, 0);
    drv(0, 0, 0);

    // 5: continuous stream; second word completes while the first transfers
    for (int i = 0; i < 24; i++) begin
      logic [7:0] w;
      w = 8'(i / 8 + 1);
      word_ready = !(i >= 7 && i <= 14);
      drv(1, w[7 - (i % 8)], i == 0);
      if (i == 15) begin
        chk("t5_nobubble", wv_m, 1); chk("t5_word2", wo_m, 8'h02); chk("t5_ovf", ov_m, 0);
      end
    end
    chk("t5_word3", wo_m, 8'h03); chk("t5_ovf_end", ov_m, 0);
    word_ready = 1; drv(0, 0, 0);

    // 6: asynchronous reset mid-word with a held word
    word_ready = 0;
    send_word(8'h3C, 1);
    for (int i = 0; i < 5; i++) drv(1, 1, 0);
    chk("t6_cnt5", bc_m, 5); chk("t6_valid", wv_m, 1);
    #2 rst = 1;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_word", wo_m, 0); chk("t6_rst_valid", wv_m, 0);
    @(negedge clk); rst = 0;
    word_ready = 1;
    for (int i = 0; i < 4; i++) drv(1, 1, 0);
    chk("t6_ignored", bc_m, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      word_ready = ($urandom % 3) != 0;
      clr_ovf    = ($urandom % 8) == 0;
      drv(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0);
    end
    clr_ovf = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
